// File: rtl/floor_request_queue.sv
// Floor-call request queue: synchronizes and debounces call switches, latches
// edge-triggered requests and issues one SCAN-ordered target floor at a time.
module floor_request_queue #(
    parameter int FLOORS    = 4,
    parameter int DB_CYCLES = 500000,
    localparam int FW       = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLOORS-1:0] sw,
    input  logic [FW-1:0]     cur_floor,
    input  logic              arrive,
    output logic [FLOORS-1:0] pending,
    output logic              target_valid,
    output logic [FW-1:0]     target_floor,
    output logic              dir_up
);

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [FLOORS-1:0] r_sync_p0;
    logic [FLOORS-1:0] r_sync_p1;
    logic [FLOORS-1:0] r_db_p2;
    logic [FLOORS-1:0] r_db_q_p3;
    logic [CW-1:0]     r_cnt [FLOORS];
    logic [FLOORS-1:0] r_pending;
    logic              r_target_valid;
    logic [FW-1:0]     r_target_floor;
    logic              r_dir_up;

    logic [FW-1:0]     w_cur;
    logic [FLOORS-1:0] w_rise;
    logic [FLOORS-1:0] w_clr;
    logic [FLOORS-1:0] w_pending_nxt;
    logic              w_up_found;
    logic [FW-1:0]     w_up_floor;
    logic              w_dn_found;
    logic [FW-1:0]     w_dn_floor;

    function automatic logic [FW-1:0] clamp_floor(input logic [FW-1:0] f);
        if (int'(f) >= FLOORS)
            return FW'(FLOORS - 1);
        return f;
    endfunction

    assign w_cur = clamp_floor(cur_floor);

    // Stage p0/p1: two-flop synchronizer; stage p2: debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_db_p2   <= '0;
            for (int i = 0; i < FLOORS; i++)
                r_cnt[i] <= '0;
        end else begin
            r_sync_p0 <= sw;
            r_sync_p1 <= r_sync_p0;
            for (int i = 0; i < FLOORS; i++) begin
                if (r_sync_p1[i] == r_db_p2[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db_p2[i] <= r_sync_p1[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Stage p3: edge detect and request latch; a clear beats a same-bit set
    assign w_rise        = r_db_p2 & ~r_db_q_p3;
    assign w_clr         = arrive ? (FLOORS'(1) << w_cur) : '0;
    assign w_pending_nxt = (r_pending | w_rise) & ~w_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_q_p3 <= '0;
            r_pending <= '0;
        end else begin
            r_db_q_p3 <= r_db_p2;
            r_pending <= w_pending_nxt;
        end
    end

    // Nearest pending floor strictly above and strictly below the car
    always_comb begin
        w_up_found = 1'b0;
        w_up_floor = '0;
        w_dn_found = 1'b0;
        w_dn_floor = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (i > int'(w_cur))) begin
                w_up_found = 1'b1;
                w_up_floor = FW'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (r_pending[i] && (i < int'(w_cur))) begin
                w_dn_found = 1'b1;
                w_dn_floor = FW'(i);
            end
        end
    end

    // Stage p4: SCAN target selection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target_valid <= 1'b0;
            r_target_floor <= '0;
            r_dir_up       <= 1'b1;
        end else if (r_pending == '0) begin
            r_target_valid <= 1'b0;
        end else begin
            r_target_valid <= 1'b1;
            if (r_pending[w_cur]) begin
                r_target_floor <= w_cur;
            end else if (r_dir_up && w_up_found) begin
                r_target_floor <= w_up_floor;
            end else if (!r_dir_up && w_dn_found) begin
                r_target_floor <= w_dn_floor;
            end else begin
                r_dir_up       <= ~r_dir_up;
                r_target_floor <= r_dir_up ? w_dn_floor : w_up_floor;
            end
        end
    end

    assign pending      = r_pending;
    assign target_valid = r_target_valid;
    assign target_floor = r_target_floor;
    assign dir_up       = r_dir_up;

endmodule

// File: tb/tb_floor_request_queue.sv
// Bench for floor_request_queue: directed call/arrival sequences checked every
// cycle against a history-based request model, plus literal expectations.
module tb_floor_request_queue;

    localparam int FLOORS = 4;
    localparam int DB     = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'b0000;
    logic [1:0] cur_floor = 2'd0;
    logic       arrive = 1'b0;
    logic [3:0] pending;
    logic       target_valid;
    logic [1:0] target_floor;
    logic       dir_up;

    int n_checks = 0;
    int n_fail   = 0;

    floor_request_queue #(
        .FLOORS   (FLOORS),
        .DB_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw          (sw),
        .cur_floor   (cur_floor),
        .arrive      (arrive),
        .pending     (pending),
        .target_valid(target_valid),
        .target_floor(target_floor),
        .dir_up      (dir_up)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: debounced level flips once the last DB synchronized samples all
    // disagree with it; target is the nearest pending floor along the sweep.
    logic [3:0]    m_s1, m_s, m_db, m_dbq, m_pend;
    logic [DB-1:0] m_hist [FLOORS];
    logic          m_tv, m_up;
    logic [1:0]    m_tf;

    function automatic int clampf(input logic [1:0] f);
        return (int'(f) >= FLOORS) ? FLOORS - 1 : int'(f);
    endfunction

    function automatic int nearest(input logic [3:0] p, input int c, input logic up);
        int best = -1;
        for (int f = 0; f < FLOORS; f++) begin
            if (p[f] && (up ? (f > c) : (f < c))) begin
                if (best < 0 || ((f > c ? f - c : c - f) < (best > c ? best - c : c - best)))
                    best = f;
            end
        end
        return best;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1  <= '0;
            m_s   <= '0;
            m_db  <= '0;
            m_dbq <= '0;
            m_pend <= '0;
            for (int i = 0; i < FLOORS; i++)
                m_hist[i] <= '0;
            m_tv <= 1'b0;
            m_tf <= '0;
            m_up <= 1'b1;
        end else begin
            m_s1 <= sw;
            m_s  <= m_s1;
            for (int i = 0; i < FLOORS; i++) begin
                m_hist[i] <= {m_hist[i][DB-2:0], m_s[i]};
                if ({m_hist[i][DB-2:0], m_s[i]} == {DB{~m_db[i]}})
                    m_db[i] <= ~m_db[i];
            end
            m_dbq  <= m_db;
            m_pend <= (m_pend | (m_db & ~m_dbq)) &
                      ~(arrive ? (4'b0001 << clampf(cur_floor)) : 4'b0000);
            if (m_pend == 4'b0000) begin
                m_tv <= 1'b0;
            end else begin
                m_tv <= 1'b1;
                if (m_pend[clampf(cur_floor)]) begin
                    m_tf <= 2'(clampf(cur_floor));
                end else if (nearest(m_pend, clampf(cur_floor), m_up) >= 0) begin
                    m_tf <= 2'(nearest(m_pend, clampf(cur_floor), m_up));
                end else begin
                    m_up <= ~m_up;
                    m_tf <= 2'(nearest(m_pend, clampf(cur_floor), ~m_up));
                end
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_pending", pending, m_pend);
        check("cyc_target_valid", target_valid, m_tv);
        check("cyc_target_floor", target_floor, m_tf);
        check("cyc_dir_up", dir_up, m_up);
    end

    initial begin
        cyc(2);
        rst = 1'b0;
        check("rst_pending", pending, 0);
        check("rst_target_valid", target_valid, 0);
        check("rst_target_floor", target_floor, 0);
        check("rst_dir_up", dir_up, 1);

        // Glitch of three cycles is ignored
        sw = 4'b0100;
        cyc(3);
        sw = 4'b0000;
        cyc(10);
        check("glitch_pending", pending, 0);

        // Held press registers at edge DB+3, target one edge later
        sw = 4'b0100;
        cyc(6);
        check("hold_pending_e6", pending, 0);
        cyc(1);
        check("hold_pending_e7", pending, 4'b0100);
        check("hold_tv_e7", target_valid, 0);
        cyc(1);
        check("hold_tv_e8", target_valid, 1);
        check("hold_tf_e8", target_floor, 2);
        check("hold_dir_e8", dir_up, 1);
        sw = 4'b0000;

        // Drain: last request served, target and direction hold
        cur_floor = 2'd2;
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        check("drain_pending", pending, 0);
        check("drain_tv_e", target_valid, 1);
        cyc(1);
        check("drain_tv_e1", target_valid, 0);
        check("drain_tf_e1", target_floor, 2);
        check("drain_dir_e1", dir_up, 1);

        // SCAN: continue upward, then reverse
        cyc(10);
        cur_floor = 2'd1;
        sw = 4'b1001;
        cyc(7);
        sw = 4'b0000;
        check("scan_pending", pending, 4'b1001);
        cyc(1);
        check("scan_tf_up", target_floor, 3);
        check("scan_dir_up", dir_up, 1);
        cur_floor = 2'd3;
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        check("scan_pending_after_arrive", pending, 4'b0001);
        cyc(1);
        check("scan_tf_reverse", target_floor, 0);
        check("scan_dir_reverse", dir_up, 0);

        // Current-floor priority while sweeping down
        cur_floor = 2'd0;
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        cyc(10);
        check("prio_dir_before", dir_up, 0);
        cur_floor = 2'd2;
        sw = 4'b0110;
        cyc(7);
        sw = 4'b0000;
        check("prio_pending", pending, 4'b0110);
        cyc(1);
        check("prio_tf_cur", target_floor, 2);
        check("prio_dir", dir_up, 0);
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        check("prio_pending_after", pending, 4'b0010);
        cyc(1);
        check("prio_tf_next", target_floor, 1);
        check("prio_dir_next", dir_up, 0);

        // Set and clear on the same bit: clear wins; other bit still sets
        cur_floor = 2'd1;
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        cyc(10);
        cur_floor = 2'd2;
        sw = 4'b0101;
        cyc(6);
        arrive = 1'b1;
        cyc(1);
        arrive = 1'b0;
        check("simul_pending", pending, 4'b0001);
        cyc(1);
        check("simul_tv", target_valid, 1);
        check("simul_tf", target_floor, 0);

        // Asynchronous reset with all switches held, then fresh registration
        sw = 4'b1111;
        #2 rst = 1'b1;
        #1;
        check("async_rst_pending", pending, 0);
        check("async_rst_tv", target_valid, 0);
        check("async_rst_tf", target_floor, 0);
        check("async_rst_dir", dir_up, 1);
        cyc(3);
        rst = 1'b0;
        cyc(6);
        check("rel_pending_e6", pending, 0);
        cyc(1);
        check("rel_pending_e7", pending, 4'b1111);
        check("rel_tv_e7", target_valid, 0);
        cyc(1);
        check("rel_tv_e8", target_valid, 1);
        check("rel_tf_e8", target_floor, 2);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
